// File: rtl/pgm_ddram_arbiter_if.sv
// Requester and DDRAM read-port bundle for pgm_ddram_arbiter.
// slave = arbiter side, master = requesters plus DDRAM model side.
interface pgm_ddram_arbiter_if #(
    parameter int NREQ = 3,
    parameter int AW   = 29
);
    logic [NREQ-1:0]    req_rd;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ-1:0]    req_ack;
    logic [NREQ-1:0]    rsp_valid;
    logic [63:0]        rsp_data;
    logic               ddram_rd;
    logic [AW-1:0]      ddram_addr;
    logic               ddram_busy;
    logic [63:0]        ddram_dout;
    logic               ddram_dout_ready;

    modport slave (
        input  req_rd, req_addr, ddram_busy,
        input  ddram_dout, ddram_dout_ready,
        output req_ack, rsp_valid, rsp_data,
        output ddram_rd, ddram_addr
    );

    modport master (
        output req_rd, req_addr, ddram_busy,
        output ddram_dout, ddram_dout_ready,
        input  req_ack, rsp_valid, rsp_data,
        input  ddram_rd, ddram_addr
    );
endinterface

// File: rtl/pgm_ddram_arbiter.sv
// Read arbiter/sequencer for the shared DDRAM graphics port, one read in flight.
// Define PGM_ARB_RR_EN for round-robin; default is fixed priority (index 0 first).
module pgm_ddram_arbiter #(
    parameter int NREQ = 3,
    parameter int AW   = 29
) (
    input  logic                 clk,
    input  logic                 reset,
    pgm_ddram_arbiter_if.slave   bus,
    output logic [2:0]           grant_idx,
    output logic                 arb_busy
);
    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_DATA
    } state_t;

    state_t state;

    logic [2:0]      win;
    logic            win_vld;
    logic [AW-1:0]   win_addr;
    logic [NREQ-1:0] one;

    assign one = {{(NREQ-1){1'b0}}, 1'b1};
    assign win_addr = bus.req_addr[int'(win)*AW +: AW];

`ifdef PGM_ARB_RR_EN
    logic [2:0] last;

    // Search starts one past the last grant so nobody starves.
    always_comb begin : rr_pick
        int j;
        j = 0;
        win = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            j = (int'(last) + 1 + k) % NREQ;
            if (!win_vld && bus.req_rd[j]) begin
                win = 3'(j);
                win_vld = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last <= 3'(NREQ-1);
        end else if (state == IDLE && win_vld) begin
            last <= win;
        end
    end
`else
    always_comb begin
        win = '0;
        win_vld = 1'b0;
        for (int k = NREQ-1; k >= 0; k--) begin
            if (bus.req_rd[k]) begin
                win = 3'(k);
                win_vld = 1'b1;
            end
        end
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= IDLE;
            bus.ddram_rd   <= 1'b0;
            bus.ddram_addr <= '0;
            bus.req_ack    <= '0;
            bus.rsp_valid  <= '0;
            bus.rsp_data   <= '0;
            grant_idx      <= '0;
            arb_busy       <= 1'b0;
        end else begin
            bus.req_ack   <= '0;
            bus.rsp_valid <= '0;
            unique case (state)
                IDLE: begin
                    if (win_vld) begin
                        bus.ddram_addr <= win_addr;
                        bus.ddram_rd   <= 1'b1;
                        bus.req_ack    <= one << win;
                        grant_idx      <= win;
                        arb_busy       <= 1'b1;
                        state          <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (!bus.ddram_busy) begin
                        bus.ddram_rd <= 1'b0;
                        state        <= WAIT_DATA;
                    end
                end
                WAIT_DATA: begin
                    if (bus.ddram_dout_ready) begin
                        bus.rsp_data  <= bus.ddram_dout;
                        bus.rsp_valid <= one << grant_idx;
                        arb_busy      <= 1'b0;
                        state         <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pgm_ddram_arbiter.sv
// Self-checking bench for pgm_ddram_arbiter: vector table, scoreboard
// on the response side, and hand sequences for contention/reset/stray data.
module tb_pgm_ddram_arbiter;
    localparam int NREQ = 3;
    localparam int AW   = 29;

    logic       clk = 1'b0;
    logic       reset;
    logic [2:0] grant_idx;
    logic       arb_busy;

    pgm_ddram_arbiter_if #(.NREQ(NREQ), .AW(AW)) bus();

    pgm_ddram_arbiter #(.NREQ(NREQ), .AW(AW)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .grant_idx(grant_idx),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [NREQ-1:0] v;
        logic [63:0]     d;
    } rsp_t;
    rsp_t sbq[$];

    typedef struct {
        logic [2:0]    req;
        logic [2:0]    ack;
        logic [AW-1:0] addr;
        int            busy;
        int            lat;
        logic [63:0]   data;
    } vec_t;
    vec_t tbl[6];

`ifdef PGM_ARB_RR_EN
    int rr_ptr = NREQ-1;
`endif

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    function automatic int oh2i(input logic [2:0] oh);
        for (int i = 0; i < NREQ; i++)
            if (oh[i]) return i;
        return 0;
    endfunction

    function automatic logic [2:0] pick(input logic [2:0] req);
`ifdef PGM_ARB_RR_EN
        for (int k = 0; k < NREQ; k++) begin
            int j;
            j = (rr_ptr + 1 + k) % NREQ;
            if (req[j]) return 3'b001 << j;
        end
`else
        for (int k = 0; k < NREQ; k++)
            if (req[k]) return 3'b001 << k;
`endif
        return 3'b000;
    endfunction

    always @(negedge clk) begin
        if (!reset && |bus.rsp_valid) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rsp_unexpected: got valid=%b data=%h want none",
                         bus.rsp_valid, bus.rsp_data);
            end else begin
                rsp_t e;
                e = sbq.pop_front();
                chk("rsp_valid", 64'(bus.rsp_valid), 64'(e.v));
                chk("rsp_data", bus.rsp_data, e.d);
            end
        end
    end

    task automatic run(input logic [2:0] req, input logic [2:0] ack,
                       input logic [AW-1:0] addr, input int busy_n,
                       input int lat, input logic [63:0] data,
                       input bit hold);
        bit got;
        bit stable;
        got = 0;
        bus.req_rd = req;
        bus.ddram_busy = (busy_n > 0);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|bus.req_ack) begin
                got = 1;
                break;
            end
        end
        if (!got) begin
            chk("ack_timeout", 64'(0), 64'(1));
            bus.req_rd = '0;
            bus.ddram_busy = 1'b0;
            return;
        end
        chk("req_ack", 64'(bus.req_ack), 64'(ack));
        chk("ddram_addr", 64'(bus.ddram_addr), 64'(addr));
        chk("ddram_rd_up", 64'(bus.ddram_rd), 64'(1));
        chk("grant_idx", 64'(grant_idx), 64'(oh2i(ack)));
`ifdef PGM_ARB_RR_EN
        rr_ptr = oh2i(bus.req_ack);
`endif
        if (!hold) bus.req_rd = '0;
        stable = 1;
        for (int i = 0; i < busy_n; i++) begin
            @(negedge clk);
            if (bus.ddram_rd !== 1'b1 || bus.ddram_addr !== addr ||
                bus.req_ack !== '0)
                stable = 0;
        end
        if (busy_n > 0) chk("busy_hold", 64'(stable), 64'(1));
        bus.ddram_busy = 1'b0;
        @(negedge clk);
        chk("rd_drop", 64'(bus.ddram_rd), 64'(0));
        chk("ack_pulse", 64'(bus.req_ack), 64'(0));
        chk("arb_busy_wait", 64'(arb_busy), 64'(1));
        for (int i = 1; i < lat; i++) @(negedge clk);
        bus.ddram_dout = data;
        bus.ddram_dout_ready = 1'b1;
        sbq.push_back('{v: ack, d: data});
        @(negedge clk);
        bus.ddram_dout_ready = 1'b0;
        chk("arb_idle", 64'(arb_busy), 64'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ack"}, 64'(bus.req_ack), 64'(0));
        chk({tag, "_rspv"}, 64'(bus.rsp_valid), 64'(0));
        chk({tag, "_rspd"}, bus.rsp_data, 64'(0));
        chk({tag, "_rd"}, 64'(bus.ddram_rd), 64'(0));
        chk({tag, "_addr"}, 64'(bus.ddram_addr), 64'(0));
        chk({tag, "_gidx"}, 64'(grant_idx), 64'(0));
        chk({tag, "_busy"}, 64'(arb_busy), 64'(0));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        logic [AW-1:0] b2b_addr[3];
        logic [2:0]    exp;
        logic [63:0]   prev;
        bit            got;

        tbl[0] = '{3'b010, 3'b010, 29'h0001234, 0, 1, 64'hDEADBEEF_CAFEF00D};
        tbl[1] = '{3'b001, 3'b001, 29'h0000100, 5, 2, 64'h01234567_89ABCDEF};
        tbl[2] = '{3'b100, 3'b100, 29'h1ABCDEF, 1, 3, 64'hFFFFFFFF_00000001};
        tbl[3] = '{3'b110, 3'b010, 29'h0001234, 0, 1, 64'h00000000_00000000};
        tbl[4] = '{3'b011, 3'b001, 29'h0000100, 0, 1, 64'h13579BDF_2468ACE0};
        tbl[5] = '{3'b100, 3'b100, 29'h1ABCDEF, 2, 4, 64'hA5A5A5A5_5A5A5A5A};

        reset = 1'b1;
        bus.req_rd = '0;
        bus.req_addr = {29'h1ABCDEF, 29'h0001234, 29'h0000100};
        bus.ddram_busy = 1'b0;
        bus.ddram_dout = '0;
        bus.ddram_dout_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        reset = 1'b0;

        for (int i = 0; i < 6; i++)
            run(tbl[i].req, tbl[i].ack, tbl[i].addr, tbl[i].busy,
                tbl[i].lat, tbl[i].data, 1'b0);

        prev = tbl[5].data;
        @(negedge clk);
        bus.ddram_dout = 64'h11112222_33334444;
        bus.ddram_dout_ready = 1'b1;
        @(negedge clk);
        bus.ddram_dout_ready = 1'b0;
        chk("stray_valid", 64'(bus.rsp_valid), 64'(0));
        chk("stray_data", bus.rsp_data, prev);
        chk("stray_idle", 64'(arb_busy), 64'(0));

        for (int i = 0; i < 6; i++) begin
            exp = pick(3'b111);
            run(3'b111, exp, bus.req_addr[oh2i(exp)*AW +: AW], 0, 1,
                64'hC0DE0000_00000000 | 64'(i), (i < 5));
        end

        bus.req_rd = 3'b010;
        got = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (|bus.req_ack) begin
                got = 1;
                break;
            end
        end
        chk("rst_seq_ack", 64'(got), 64'(1));
        bus.req_rd = '0;
        @(negedge clk);
        chk("rst_seq_wait_rd", 64'(bus.ddram_rd), 64'(0));
        chk("rst_seq_wait_busy", 64'(arb_busy), 64'(1));
        reset = 1'b1;
        @(negedge clk);
        chk_all_zero("midreset");
        reset = 1'b0;
`ifdef PGM_ARB_RR_EN
        rr_ptr = NREQ-1;
`endif
        run(3'b100, 3'b100, 29'h1ABCDEF, 0, 1, 64'h0BADF00D_12345678, 1'b0);

        b2b_addr[0] = 29'h10;
        b2b_addr[1] = 29'h20;
        b2b_addr[2] = 29'h30;
        for (int k = 0; k < 3; k++) begin
            bus.req_addr[AW-1:0] = b2b_addr[k];
            run(3'b001, 3'b001, b2b_addr[k], 0, 1,
                64'hB2B00000_00000000 | 64'(k), (k < 2));
        end

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sbq.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
